// File: rtl/fma_pkg.sv
// Shared FMA datapath constants and types: mantissa/half/product widths,
// the mantissa multiply sequencer state encoding and its request bundle.
package fma_pkg;
    localparam int MANT_W    = 53;
    localparam int HALF_W    = 27;
    localparam int PROD_W    = 106;
    localparam int PP_W      = 2 * HALF_W;
    localparam int REQ_TAG_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISS0,
        S_ISS1,
        S_WAIT,
        S_CAP0,
        S_CAP1,
        S_DONE
    } mul_seq_state_t;

    typedef struct packed {
        logic [MANT_W-1:0]    a;
        logic [MANT_W-1:0]    b;
        logic [REQ_TAG_W-1:0] tag;
    } mul_seq_req_t;
endpackage

// File: rtl/mul_seq_if.sv
// Request/response handshake plus the two shared 27x27 multiplier ports.
// slave = the sequencer, master = the surrounding FMA pipeline.
interface mul_seq_if #(
    parameter int TAG_W = 4
) ();
    import fma_pkg::*;

    logic                kill;
    logic                req_valid;
    logic                req_ready;
    logic [MANT_W-1:0]   req_a;
    logic [MANT_W-1:0]   req_b;
    logic [TAG_W-1:0]    req_tag;
    logic                resp_valid;
    logic                resp_ready;
    logic [PROD_W-1:0]   resp_prod;
    logic [TAG_W-1:0]    resp_tag;
    logic                mul0_en;
    logic [HALF_W-1:0]   mul0_in_1;
    logic [HALF_W-1:0]   mul0_in_2;
    logic [PP_W-1:0]     mul0_out;
    logic                mul1_en;
    logic [HALF_W-1:0]   mul1_in_1;
    logic [HALF_W-1:0]   mul1_in_2;
    logic [PP_W-1:0]     mul1_out;

    modport slave (
        input  kill, req_valid, req_a, req_b, req_tag, resp_ready, mul0_out, mul1_out,
        output req_ready, resp_valid, resp_prod, resp_tag,
               mul0_en, mul0_in_1, mul0_in_2, mul1_en, mul1_in_1, mul1_in_2
    );

    modport master (
        output kill, req_valid, req_a, req_b, req_tag, resp_ready, mul0_out, mul1_out,
        input  req_ready, resp_valid, resp_prod, resp_tag,
               mul0_en, mul0_in_1, mul0_in_2, mul1_en, mul1_in_1, mul1_in_2
    );
endinterface

// File: rtl/mul_seq.sv
// 53x53 mantissa multiply built from four 27x27 partial products, issued two
// per cycle on the shared multipliers and accumulated into a 106-bit result.
module mul_seq
    import fma_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 4
) (
    input  logic     clk,
    input  logic     reset,
    mul_seq_if.slave bus
);
    localparam int            CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (MUL_LAT > 2) ? CNT_W'(MUL_LAT - 3) : '0;

    mul_seq_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [MANT_W-1:0]   a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [HALF_W-1:0]   al, ah, bl, bh;
    logic                accept;
    logic                mul_en;

    assign al = a_q[HALF_W-1:0];
    assign ah = {1'b0, a_q[MANT_W-1:HALF_W]};
    assign bl = b_q[HALF_W-1:0];
    assign bh = {1'b0, b_q[MANT_W-1:HALF_W]};

    assign accept = (state_q == S_IDLE) && bus.req_valid && !bus.kill;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req_valid) state_d = S_ISS0;
            S_ISS0:  state_d = S_ISS1;
            S_ISS1:  state_d = (MUL_LAT == 2) ? S_CAP0 : S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_CAP0;
            S_CAP0:  state_d = S_CAP1;
            S_CAP1:  state_d = S_DONE;
            S_DONE:  if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.kill) state_d = S_IDLE;
    end

    always_comb begin
        bus.req_ready  = (state_q == S_IDLE) && !bus.kill && reset;
        bus.resp_valid = (state_q == S_DONE);
        bus.resp_prod  = acc_q;
        bus.resp_tag   = tag_q;
        mul_en         = state_q inside {S_ISS0, S_ISS1, S_WAIT, S_CAP0, S_CAP1};
        bus.mul0_en    = mul_en;
        bus.mul1_en    = mul_en;
        bus.mul0_in_1  = '0;
        bus.mul0_in_2  = '0;
        bus.mul1_in_1  = '0;
        bus.mul1_in_2  = '0;
        case (state_q)
            S_ISS0: begin
                bus.mul0_in_1 = al; bus.mul0_in_2 = bl;
                bus.mul1_in_1 = ah; bus.mul1_in_2 = bl;
            end
            S_ISS1: begin
                bus.mul0_in_1 = al; bus.mul0_in_2 = bh;
                bus.mul1_in_1 = ah; bus.mul1_in_2 = bh;
            end
            default: ;
        endcase
    end

    // Products return MUL_LAT cycles after issue, so CAP0 sees the ISS0 pair
    // (low half of b) and CAP1 the ISS1 pair (high half of b).
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        tag_d = tag_q;
        if (accept) begin
            a_d   = bus.req_a;
            b_d   = bus.req_b;
            tag_d = bus.req_tag;
        end
        case (state_q)
            S_ISS1: cnt_d = CNT_INIT;
            S_WAIT: cnt_d = cnt_q - CNT_W'(1);
            S_CAP0: acc_d = PROD_W'(bus.mul0_out) + (PROD_W'(bus.mul1_out) << HALF_W);
            S_CAP1: acc_d = acc_q + (PROD_W'(bus.mul0_out) << HALF_W)
                                  + (PROD_W'(bus.mul1_out) << (2 * HALF_W));
            default: ;
        endcase
        if (bus.kill) acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            tag_q <= tag_d;
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: fixed-latency multiplier models, a cycle-level reference
// of the handshake/issue timing, and a second MUL_LAT=2 instance.
module tb_mul_seq;
    import fma_pkg::*;

    localparam int L  = 3;
    localparam int TW = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    mul_seq_if #(.TAG_W(TW)) bus  ();
    mul_seq_if #(.TAG_W(TW)) bus2 ();

    mul_seq #(.MUL_LAT(L), .TAG_W(TW)) dut  (.clk(clk), .reset(rst_n),  .bus(bus));
    mul_seq #(.MUL_LAT(2), .TAG_W(TW)) dut2 (.clk(clk), .reset(rst2_n), .bus(bus2));

    // Fixed-latency multipliers; idle slots are filled with garbage.
    logic [PP_W-1:0] p0 [L];
    logic [PP_W-1:0] p1 [L];
    logic [PP_W-1:0] q0 [2];
    logic [PP_W-1:0] q1 [2];
    always @(posedge clk) begin
        p0[0] <= bus.mul0_en ? PP_W'(bus.mul0_in_1) * PP_W'(bus.mul0_in_2) : PP_W'({$urandom, $urandom});
        p1[0] <= bus.mul1_en ? PP_W'(bus.mul1_in_1) * PP_W'(bus.mul1_in_2) : PP_W'({$urandom, $urandom});
        for (int i = 1; i < L; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
        end
        q0[0] <= bus2.mul0_en ? PP_W'(bus2.mul0_in_1) * PP_W'(bus2.mul0_in_2) : PP_W'({$urandom, $urandom});
        q1[0] <= bus2.mul1_en ? PP_W'(bus2.mul1_in_1) * PP_W'(bus2.mul1_in_2) : PP_W'({$urandom, $urandom});
        q0[1] <= q0[0];
        q1[1] <= q1[0];
    end
    assign bus.mul0_out  = p0[L-1];
    assign bus.mul1_out  = p1[L-1];
    assign bus2.mul0_out = q0[1];
    assign bus2.mul1_out = q1[1];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state, owned by the compare process.
    bit                busy    = 1'b0;
    bit                chk_on  = 1'b0;
    int                cyc     = 0;
    int                acc_cyc = 0;
    int                d       = 0;
    int                en_cnt  = 0;
    int                n_deliv = 0;
    int                last_lat = 0;
    int                last_en  = 0;
    logic [MANT_W-1:0] e_a, e_b;
    logic [PROD_W-1:0] e_prod;
    logic [TW-1:0]     e_tag;
    logic [PROD_W-1:0] last_prod;
    logic [TW-1:0]     last_tag;
    bit                bp_on   = 1'b0;
    bit                l2_done = 1'b0;

    initial forever begin
        logic              issue, en_exp;
        logic [HALF_W-1:0] al_e, ah_e, i2;
        @(negedge clk);
        cyc++;
        d = cyc - acc_cyc;
        if (chk_on) begin
            issue  = busy && (d == 1 || d == 2);
            en_exp = busy && d >= 1 && d <= L + 2;
            al_e   = e_a[HALF_W-1:0];
            ah_e   = {1'b0, e_a[MANT_W-1:HALF_W]};
            i2     = (d == 1) ? e_b[HALF_W-1:0] : {1'b0, e_b[MANT_W-1:HALF_W]};
            chk("req_ready", bus.req_ready, !busy && !bus.kill && rst_n);
            chk("resp_valid", bus.resp_valid, busy && d >= L + 3);
            if (busy && d >= L + 3) begin
                chk("resp_prod", bus.resp_prod, e_prod);
                chk("resp_tag", bus.resp_tag, e_tag);
            end
            chk("mul0_en", bus.mul0_en, en_exp);
            chk("mul1_en", bus.mul1_en, en_exp);
            chk("mul0_in_1", bus.mul0_in_1, issue ? al_e : '0);
            chk("mul0_in_2", bus.mul0_in_2, issue ? i2 : '0);
            chk("mul1_in_1", bus.mul1_in_1, issue ? ah_e : '0);
            chk("mul1_in_2", bus.mul1_in_2, issue ? i2 : '0);
            if (bus.mul0_en) en_cnt++;
        end
        if (!rst_n || bus.kill) begin
            busy = 1'b0;
        end else if (bus.req_valid && bus.req_ready) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            e_a     = bus.req_a;
            e_b     = bus.req_b;
            e_tag   = bus.req_tag;
            e_prod  = PROD_W'(bus.req_a) * PROD_W'(bus.req_b);
            en_cnt  = 0;
        end else if (busy && bus.resp_valid && bus.resp_ready) begin
            busy      = 1'b0;
            n_deliv++;
            last_prod = bus.resp_prod;
            last_tag  = bus.resp_tag;
            last_lat  = d;
            last_en   = en_cnt;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 bus.resp_ready = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic do_req(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b, input logic [TW-1:0] tag);
        bit ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!ok) chk("req_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_resp();
        int start = n_deliv;
        for (int k = 0; k < 200 && n_deliv == start; k++) @(posedge clk);
        #1;
        if (n_deliv == start) chk("resp_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        bus.kill = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("rst_prod", bus.resp_prod, '0);
        chk("rst_tag", bus.resp_tag, '0);
        chk("rst_ready", bus.req_ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_req(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 4'd5);
        wait_resp();
        chk("one_prod", last_prod, 106'd1 << 104);
        chk("one_tag", last_tag, 4'd5);
        chk("one_lat", last_lat, 6);

        do_req('1, '1, 4'd9);
        wait_resp();
        chk("max_prod", last_prod, {52'hF_FFFF_FFFF_FFFF, 54'd1});
        chk("max_en_cycles", last_en, 5);

        bp_on = 1'b1;
        base  = n_deliv;
        for (int i = 0; i < 1000; i++) begin
            logic [MANT_W-1:0] a, b;
            a = MANT_W'({$urandom, $urandom});
            b = MANT_W'({$urandom, $urandom});
            if (i % 97 == 0) a = '1;
            if (i % 89 == 0) b = '0;
            do_req(a, b, TW'($urandom));
        end
        for (int k = 0; k < 200 && busy; k++) @(posedge clk);
        #1 chk("rand_deliveries", n_deliv - base, 1000);
        bp_on = 1'b0;
        @(posedge clk); #1;

        base = n_deliv;
        do_req(53'd7, 53'd11, 4'd3);
        repeat (2) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        bus.req_valid = 1'b1; bus.req_a = 53'd3; bus.req_b = 53'd5; bus.req_tag = 4'd12;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        do_req(53'd3, 53'd5, 4'd12);
        wait_resp();
        chk("kill_prod", last_prod, 106'd15);
        chk("kill_tag", last_tag, 4'd12);
        chk("kill_deliveries", n_deliv - base, 1);

        do_req(53'h1F_0123_4567_89AB, 53'h15_5555_5555_5555, 4'd6);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_prod", bus.resp_prod, '0);
        chk("midrst_tag", bus.resp_tag, '0);
        chk("midrst_valid", bus.resp_valid, 1'b0);
        chk("midrst_en", bus.mul0_en, 1'b0);
        @(posedge clk); #1;
        do_req(53'd12345, 53'd678, 4'd10);
        wait_resp();
        chk("postrst_prod", last_prod, 106'd8369910);
        chk("postrst_tag", last_tag, 4'd10);

        for (int k = 0; k < 500 && !l2_done; k++) @(posedge clk);
        if (!l2_done) chk("lat2_timeout", 1'b0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // MUL_LAT = 2 instance: back-to-back requests, WAIT skipped.
    initial begin
        bus2.kill = 1'b0; bus2.req_valid = 1'b0; bus2.resp_ready = 1'b1;
        bus2.req_a = '0; bus2.req_b = '0; bus2.req_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst2_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [MANT_W-1:0] a, b;
            bit ok, got;
            int lat;
            a = MANT_W'({$urandom, $urandom});
            b = MANT_W'({$urandom, $urandom});
            bus2.req_valid = 1'b1; bus2.req_a = a; bus2.req_b = b; bus2.req_tag = TW'(i + 1);
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                if (bus2.req_ready) ok = 1'b1;
                @(posedge clk);
                #1;
            end
            bus2.req_valid = 1'b0;
            got = 1'b0;
            lat = 0;
            for (int k = 1; k <= 20 && !got; k++) begin
                @(negedge clk);
                if (bus2.resp_valid) begin
                    got = 1'b1;
                    lat = k;
                    chk("lat2_prod", bus2.resp_prod, PROD_W'(a) * PROD_W'(b));
                    chk("lat2_tag", bus2.resp_tag, TW'(i + 1));
                end
                @(posedge clk);
                #1;
            end
            chk("lat2_accept", ok, 1'b1);
            chk("lat2_latency", lat, 5);
        end
        l2_done = 1'b1;
    end
endmodule
